// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I definitions: opcode classes, controller states and datapath select encodings.
// Used by multicycle_ctrl and the core top level.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_WRITEBACK, ST_TRAP
  } state_e;

  typedef enum logic [1:0] {PC_ALU_RESULT = 2'b00, PC_ALU_OUT = 2'b01, PC_ALU_OUT_ALIGN = 2'b10} pc_src_e;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_REG = 2'b01, SRCA_ZERO = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {
    WB_ALU_OUT = 2'b00, WB_MEM = 2'b01, WB_IMM = 2'b10, WB_ALU_RESULT = 2'b11
  } wb_mux_e;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between multicycle_ctrl (master) and the core datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic                 ir_write;
  logic                 reg_write;
  logic                 dmem_wren;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 alu_force_add;
  logic [1:0]           writeback_mux;
  logic                 trap;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    input  opcode, branch_taken,
    output pc_write, pc_src, ir_write, reg_write, dmem_wren, alu_src_a, alu_src_b,
           alu_force_add, writeback_mux, trap, instr_count
  );
  modport slave (
    output opcode, branch_taken,
    input  pc_write, pc_src, ir_write, reg_write, dmem_wren, alu_src_a, alu_src_b,
           alu_force_add, writeback_mux, trap, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl_latency_counter.sv
// Clearable wait-state counter; done is high once the count reaches target.
module latency_counter #(
  parameter int MAX_LAT = 1,
  localparam int W      = $clog2(MAX_LAT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == target);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)           cnt_d = '0;
    else if (en && !done) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory wait states and retired-instruction counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of retiring them as NOPs.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int IMEM_LATENCY = 1,
  parameter int DMEM_LATENCY = 1,
  parameter int CNT_WIDTH    = 32
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);
  localparam int MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;
  logic                 cnt_done, cnt_en, cnt_clear;
  logic [CW-1:0]        cnt_target;
  logic                 is_load, is_store;

  pc_src_e    pc_src;
  alu_src_a_e src_a;
  alu_src_b_e src_b;
  wb_mux_e    wb_mux;
  logic       pc_write, ir_write, reg_write, dmem_wren, force_add;

  assign is_load    = (bus.opcode == OPC_LOAD);
  assign is_store   = (bus.opcode == OPC_STORE);
  assign cnt_en     = (state_q == ST_FETCH) || (state_q == ST_MEM && is_load);
  assign cnt_target = (state_q == ST_MEM) ? CW'(DMEM_LATENCY) : CW'(IMEM_LATENCY);
  assign cnt_clear  = (state_d != state_q);

  latency_counter #(.MAX_LAT(MAX_LAT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .target (cnt_target),
    .done   (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (cnt_done) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: state_d = ST_EXECUTE;
          default: state_d = ST_WRITEBACK;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!is_legal(bus.opcode)) state_d = ST_TRAP;
`endif
      end
      ST_EXECUTE:   state_d = (is_load || is_store) ? ST_MEM : ST_WRITEBACK;
      // Stores spend a single cycle in MEM; loads wait out the data latency.
      ST_MEM:       if (is_store || cnt_done) state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    dmem_wren = 1'b0;
    force_add = 1'b0;
    pc_src    = PC_ALU_RESULT;
    src_a     = SRCA_PC;
    src_b     = SRCB_REG;
    wb_mux    = WB_ALU_OUT;
    case (state_q)
      ST_FETCH: ir_write = cnt_done;
      ST_DECODE: begin
        src_b     = SRCB_IMM;
        force_add = 1'b1;
      end
      ST_EXECUTE: begin
        case (bus.opcode)
          OPC_OP:     src_a = SRCA_REG;
          OPC_OP_IMM: begin src_a = SRCA_REG; src_b = SRCB_IMM; end
          OPC_LOAD, OPC_STORE, OPC_JALR: begin
            src_a     = SRCA_REG;
            src_b     = SRCB_IMM;
            force_add = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: dmem_wren = is_store;
      ST_WRITEBACK: begin
        src_b     = SRCB_FOUR;
        force_add = 1'b1;
        pc_write  = 1'b1;
        case (bus.opcode)
          OPC_OP, OPC_OP_IMM, OPC_AUIPC: reg_write = 1'b1;
          OPC_LOAD: begin reg_write = 1'b1; wb_mux = WB_MEM; end
          OPC_LUI:  begin reg_write = 1'b1; wb_mux = WB_IMM; end
          OPC_JAL:  begin reg_write = 1'b1; wb_mux = WB_ALU_RESULT; pc_src = PC_ALU_OUT; end
          OPC_JALR: begin reg_write = 1'b1; wb_mux = WB_ALU_RESULT; pc_src = PC_ALU_OUT_ALIGN; end
          OPC_BRANCH: pc_src = bus.branch_taken ? PC_ALU_OUT : PC_ALU_RESULT;
          default: ;
        endcase
      end
      default: ;
    endcase
    // Reset overrides the decode so nothing (notably a store in MEM) leaks out.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      dmem_wren = 1'b0;
      force_add = 1'b0;
      pc_src    = PC_ALU_RESULT;
      src_a     = SRCA_PC;
      src_b     = SRCB_REG;
      wb_mux    = WB_ALU_OUT;
    end
  end

  assign instr_count_d = instr_count_q + ((state_q == ST_WRITEBACK) ? CNT_WIDTH'(1) : '0);

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
  assign trap_d   = trap_q || (state_d == ST_TRAP);
  assign bus.trap = trap_q;
`else
  assign bus.trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      instr_count_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q        <= trap_d;
`endif
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.dmem_wren     = dmem_wren;
  assign bus.alu_force_add = force_add;
  assign bus.pc_src        = pc_src;
  assign bus.alu_src_a     = src_a;
  assign bus.alu_src_b     = src_b;
  assign bus.writeback_mux = wb_mux;
  assign bus.instr_count   = instr_count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (IMEM latency 1, DMEM latency 3, 4-bit counter).
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  multicycle_ctrl_if #(.CNT_WIDTH(4)) bus ();

  multicycle_ctrl #(.IMEM_LATENCY(1), .DMEM_LATENCY(3), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Per-instruction observations, indexed by cycle number within the instruction.
  logic       r_found;
  int         r_cycles, r_ir, r_wren_n, r_wren_first;
  logic [1:0] r_pc_src, r_mux;
  logic       r_rw;
  logic [1:0] lg_a [1:40];
  logic [1:0] lg_b [1:40];
  logic       lg_f [1:40];
  logic       lg_trap [1:40];
  logic       lg_pcw [1:40];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the start of FETCH cycle 1; returns at the start of the next FETCH.
  task automatic run(input logic [6:0] op, input logic bt, input int bound);
    bus.opcode = op;
    bus.branch_taken = bt;
    r_found = 1'b0; r_cycles = 0; r_ir = 0; r_wren_n = 0; r_wren_first = 0;
    r_pc_src = 2'bxx; r_mux = 2'bxx; r_rw = 1'bx;
    for (int c = 1; c <= bound; c++) begin
      #1;
      lg_a[c] = bus.alu_src_a; lg_b[c] = bus.alu_src_b; lg_f[c] = bus.alu_force_add;
      lg_trap[c] = bus.trap; lg_pcw[c] = bus.pc_write;
      if (bus.ir_write) r_ir = c;
      if (bus.dmem_wren) begin
        if (r_wren_n == 0) r_wren_first = c;
        r_wren_n++;
      end
      if (bus.pc_write) begin
        r_found = 1'b1; r_cycles = c;
        r_pc_src = bus.pc_src; r_mux = bus.writeback_mux; r_rw = bus.reg_write;
        tick;
        break;
      end
      tick;
    end
  endtask

  initial begin
    bus.opcode = 7'b0100011;
    bus.branch_taken = 1'b0;
    repeat (3) tick;
    chk("rst_enables", {bus.pc_write, bus.ir_write, bus.reg_write, bus.dmem_wren}, 4'b0000);
    chk("rst_selects", {bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.writeback_mux, bus.alu_force_add}, 9'd0);
    chk("rst_count", bus.instr_count, 4'd0);
    chk("rst_trap", bus.trap, 1'b0);
    reset = 1'b1;

    run(7'b0110011, 1'b0, 20); // ADD
    chk("add_found", r_found, 1'b1);
    chk("add_cycles", r_cycles, 5);
    chk("add_ir_cycle", r_ir, 2);
    chk("add_rw_mux_pcsrc", {r_rw, r_mux, r_pc_src}, 5'b1_00_00);
    chk("add_dec_sel", {lg_a[3], lg_b[3], lg_f[3]}, 5'b00_10_1);
    chk("add_ex_sel", {lg_a[4], lg_b[4], lg_f[4]}, 5'b01_00_0);
    chk("add_wb_sel", {lg_a[5], lg_b[5], lg_f[5]}, 5'b00_01_1);
    chk("add_count", bus.instr_count, 4'd1);

    run(7'b1100011, 1'b1, 20); // BEQ taken
    chk("beq_t_cycles", r_cycles, 4);
    chk("beq_t_pcsrc_rw", {r_pc_src, r_rw}, 3'b01_0);
    run(7'b1100011, 1'b0, 20); // BEQ not taken
    chk("beq_n_cycles", r_cycles, 4);
    chk("beq_n_pcsrc_rw", {r_pc_src, r_rw}, 3'b00_0);
    chk("beq_count", bus.instr_count, 4'd3);

    run(7'b0000011, 1'b0, 20); // LOAD, DMEM latency 3
    chk("ld_cycles", r_cycles, 9);
    chk("ld_rw_mux_pcsrc", {r_rw, r_mux, r_pc_src}, 5'b1_01_00);
    chk("ld_no_wren", r_wren_n, 0);
    chk("ld_ex_sel", {lg_a[4], lg_b[4], lg_f[4]}, 5'b01_10_1);

    run(7'b0100011, 1'b0, 20); // STORE
    chk("st_cycles", r_cycles, 6);
    chk("st_wren_n", r_wren_n, 1);
    chk("st_wren_cycle", r_wren_first, 5);
    chk("st_rw", r_rw, 1'b0);

    run(7'b1100111, 1'b0, 20); // JALR
    chk("jalr_cycles", r_cycles, 5);
    chk("jalr_mux_pcsrc_rw", {r_mux, r_pc_src, r_rw}, 5'b11_10_1);
    run(7'b1101111, 1'b0, 20); // JAL
    chk("jal_cycles", r_cycles, 4);
    chk("jal_mux_pcsrc_rw", {r_mux, r_pc_src, r_rw}, 5'b11_01_1);
    run(7'b0110111, 1'b0, 20); // LUI
    chk("lui_cycles_mux", {r_cycles[7:0], r_mux, r_rw}, {8'd4, 2'b10, 1'b1});
    run(7'b0010111, 1'b0, 20); // AUIPC
    chk("auipc_cycles_mux", {r_cycles[7:0], r_mux, r_rw}, {8'd4, 2'b00, 1'b1});
    run(7'b0010011, 1'b0, 20); // OP-IMM
    chk("opimm_cycles", r_cycles, 5);
    chk("opimm_ex_sel", {lg_a[4], lg_b[4], lg_f[4]}, 5'b01_10_0);
    chk("count_10", bus.instr_count, 4'd10);

    // Reset in the store's MEM cycle must suppress the write strobe.
    bus.opcode = 7'b0100011;
    repeat (4) tick;
    chk("st_mem_wren", bus.dmem_wren, 1'b1);
    reset = 1'b0;
    #1;
    chk("st_rst_wren", bus.dmem_wren, 1'b0);
    tick;
    reset = 1'b1;
    chk("st_rst_count", bus.instr_count, 4'd0);
    run(7'b0110011, 1'b0, 20);
    chk("post_rst_cycles", r_cycles, 5);
    chk("post_rst_ir", r_ir, 2);
    chk("post_rst_count", bus.instr_count, 4'd1);

    for (int i = 0; i < 14; i++) run(7'b0110111, 1'b0, 20);
    chk("count_15", bus.instr_count, 4'd15);
    run(7'b0110111, 1'b0, 20);
    chk("count_wrap", bus.instr_count, 4'd0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    run(7'b1111111, 1'b0, 10);
    chk("ill_no_pcw", r_found, 1'b0);
    chk("ill_trap_c3", lg_trap[3], 1'b0);
    chk("ill_trap_c4", lg_trap[4], 1'b1);
    chk("ill_trap_c10", lg_trap[10], 1'b1);
    chk("ill_count", bus.instr_count, 4'd0);
`else
    run(7'b1111111, 1'b0, 20);
    chk("ill_cycles", r_cycles, 4);
    chk("ill_pcsrc_rw", {r_pc_src, r_rw}, 3'b00_0);
    chk("ill_count", bus.instr_count, 4'd1);
    chk("ill_trap", bus.trap, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
